// File: rtl/dac_ch_seq_ctrl.sv
// dac_ch_seq_ctrl: multi-channel DAC update sequencer.
// Holds a per-channel code table and, on a start edge, walks channels
// 0..CH_NUM-1 issuing one trigger per channel to the DAC serial driver with a
// programmable dwell between updates. Supports driver back-pressure, one-shot
// or continuous looping, abort and an end-of-pass done pulse.
module dac_ch_seq_ctrl #(
   parameter int unsigned CH_NUM  = 32,
   parameter int unsigned CH_W    = 5,
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_wr_en,
   input  logic [CH_W-1:0]    cfg_wr_ch,
   input  logic [DATA_W-1:0]  cfg_wr_data,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic               loop_en,
   input  logic               start,
   input  logic               abort,
   input  logic               dac_busy,
   output logic               dac_trig,
   output logic [CH_W-1:0]    dac_ch,
   output logic [DATA_W-1:0]  dac_din,
   output logic               seq_busy,
   output logic               seq_done
);

   localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(CH_NUM - 1);
   localparam logic [CH_W-1:0]    CH_ONE    = CH_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DWELL = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                start_s1_q, start_s1_d;
   logic                start_s2_q, start_s2_d;
   logic                start_pos;
   logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic                trig_q, trig_d;
   logic [CH_W-1:0]     ch_out_q, ch_out_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   tbl_q [CH_NUM];
   logic [DATA_W-1:0]   tbl_d [CH_NUM];
   logic [DATA_W-1:0]   rd_data;

   // Two-flop start synchroniser; a rising edge is d1 set while d2 still clear.
   always_comb begin
      start_s1_d = start;
      start_s2_d = start_s1_q;
      start_pos  = start_s1_q & ~start_s2_q;
   end

   // Code table update; out-of-range channel indices never match an entry.
   always_comb begin
      tbl_d = tbl_q;
      if (cfg_wr_en) begin
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (cfg_wr_ch == CH_W'(i)) begin
               tbl_d[i] = cfg_wr_data;
            end
         end
      end
   end

   // Table read for the channel being issued (old contents on a same-edge write).
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (ch_idx_q == CH_W'(i)) begin
            rd_data = tbl_q[i];
         end
      end
   end

   // Sequencer next-state and registered-output logic; abort outranks a start edge.
   always_comb begin
      state_d  = state_q;
      ch_idx_d = ch_idx_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
      trig_d   = 1'b0;
      ch_out_d = ch_out_q;
      din_d    = din_q;
      done_d   = 1'b0;

      if (abort) begin
         state_d = IDLE;
      end else if (start_pos) begin
         state_d  = ISSUE;
         ch_idx_d = '0;
         dwell_d  = (dwell_cycles == '0) ? DWELL_ONE : dwell_cycles;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ISSUE: begin
               if (!dac_busy) begin
                  trig_d   = 1'b1;
                  ch_out_d = ch_idx_q;
                  din_d    = rd_data;
                  cnt_d    = dwell_q - DWELL_ONE;
                  state_d  = DWELL;
               end
            end
            DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DWELL_ONE;
               end else if (ch_idx_q != LAST_CH) begin
                  ch_idx_d = ch_idx_q + CH_ONE;
                  state_d  = ISSUE;
               end else if (loop_en) begin
                  ch_idx_d = '0;
                  state_d  = ISSUE;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         ch_idx_q   <= '0;
         dwell_q    <= '0;
         cnt_q      <= '0;
         trig_q     <= 1'b0;
         ch_out_q   <= '0;
         din_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_s1_q <= start_s1_d;
         start_s2_q <= start_s2_d;
         ch_idx_q   <= ch_idx_d;
         dwell_q    <= dwell_d;
         cnt_q      <= cnt_d;
         trig_q     <= trig_d;
         ch_out_q   <= ch_out_d;
         din_q      <= din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Code table storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            tbl_q[i] <= tbl_d[i];
         end
      end
   end

   assign dac_trig = trig_q;
   assign dac_ch   = ch_out_q;
   assign dac_din  = din_q;
   assign seq_busy = busy_q;
   assign seq_done = done_q;

endmodule
